altpcierd_cdma_rx_router: RTL
=============================

// Module: altpcierd_cdma_rx_router
// PURPOSE
//  Sits directly downstream of the Avalon-ST-to-desc/data RX adapter and consumes its rx_req/rx_desc/rx_data interface.
//  Acknowledges each TLP descriptor and classifies it as completion (Cpl/CplD), request (MRd/MWr) or unsupported.
//  Routes the header to the matching header queue and the payload beats to a shared buffered data port.
//  Drives rx_ws to throttle payload; unsupported TLPs are acked, drained and counted as drops.
// PARAMETERS
//  SKID_DEPTH  4  payload skid FIFO entries, power of 2, >=4.
//  WS_THRESH   2  occupancy at or above which rx_ws asserts; must satisfy <= SKID_DEPTH-2.
// PORTS
//  clk_in       in   1    single clock
//  rst          in   1    reset, asynchronous, active-high
//  rx_req       in   1    descriptor pending; held until rx_ack
//  rx_desc      in   136  [135:128] BAR/status, [127:96] hdr DW0, [95:64] DW1, [63:0] DW2/DW3
//  rx_ack       out  1    one-cycle descriptor accept pulse
//  rx_dfr       in   1    payload still to follow
//  rx_dv        in   1    rx_data/rx_be valid
//  rx_data      in   64   payload QWORD
//  rx_be        in   8    byte enables
//  rx_ws        out  1    wait-state request to the source
//  cpl_hdr_vld  out  1    completion header valid; held until cpl_hdr_rdy
//  cpl_hdr_rdy  in   1
//  req_hdr_vld  out  1    request header valid; held until req_hdr_rdy
//  req_hdr_rdy  in   1
//  hdr_out      out  128  latched rx_desc[127:0], shared by both header queues
//  dat_vld      out  1    payload beat valid (skid FIFO not empty and not dropping)
//  dat_rdy      in   1
//  dat_data     out  64
//  dat_be       out  8
//  dat_last     out  1    final beat of the TLP
// BEHAVIOUR
//  Reset: rx_ack=0, rx_ws=0, *_hdr_vld=0, dat_vld=0, FIFO empty, FSM=IDLE, counters=0. Reset mid-TLP aborts it with no flush.
//  Decode from hdr DW0 = rx_desc[127:96]: fmt=[126:125], type=[124:120].
//    Cpl/CplD when type=5'b01010; request when type=5'b00000 (MRd/MWr, 3DW or 4DW); all other types are DROP.
//  FSM:
//    IDLE: on rx_req=1 with the target hdr_vld=0, go to ACK.
//    ACK: rx_ack=1 for exactly 1 cycle; latch hdr_out. Set the class hdr_vld unless DROP.
//         If fmt[1] (has payload), go to DATA; else go to IDLE.
//    DATA: capture every rx_dv=1 beat into the FIFO; on DROP, beats are discarded instead.
//         The beat with rx_dv=1 && rx_dfr=0 is last; tag it dat_last, then go to IDLE.
//  rx_req arriving in ACK or DATA is not acked until the FSM has returned to IDLE; minimum ack spacing is 2 cycles.
//  Header handshake: hdr_vld falls the cycle after hdr_vld & hdr_rdy.
//    A new TLP of the same class waits in IDLE while that hdr_vld is still set.
//    A TLP of the other class may proceed.
//  Skid FIFO: write on rx_dv, read on dat_vld & dat_rdy; a simultaneous write and read at full is legal.
//    rx_ws is registered: rx_ws <= (occupancy_next >= WS_THRESH).
//    Source latency after rx_ws is <=2 beats; overflow is impossible and is checked by an assertion.
//    Pointers wrap modulo SKID_DEPTH; the count is log2(SKID_DEPTH)+1 bits.
//  Data is never presented before its header's hdr_vld has been asserted. Latency: rx_dv beat to dat_vld = 1 cycle.
// CONFIGURATION
//  RX_ROUTE_STATS_EN defined:
//    Adds outputs cpl_cnt, req_cnt, drop_cnt (16b each), incremented in the ACK cycle.
//    The counters saturate at 16'hFFFF and reset to 0.
//  Undefined: no counter ports and no counter logic.
// STRUCTURE
//  Package altpcierd_cdma_rx_pkg holds:
//    TYPE_CPL=5'b01010 and TYPE_MEM=5'b00000 constants
//    the route class enum {RT_CPL, RT_REQ, RT_DROP}
//    the FSM state enum {IDLE, ACK, DATA}
//  Sub-module altpcierd_cdma_rx_skid_fifo: {last,be,data} FIFO of 73 bits x SKID_DEPTH, with a count output.
// TESTING
//  MRd 3DW with no payload, rx_req=1 -> rx_ack pulse the next cycle; req_hdr_vld=1 with hdr_out=desc[127:0]; dat_vld never asserts.
//  CplD of 4 QWORDs with dat_rdy=1 -> cpl_hdr_vld set; 4 dat_vld beats with data matching, dat_last on the 4th.
//  MWr of 8 QWORDs with dat_rdy=0 -> rx_ws=1 once 2 beats are queued; no overflow; after dat_rdy=1 all 8 beats exit in order.
//  Msg type 5'b10000 with 2 QWORDs -> rx_ack pulse; no hdr_vld, no dat_vld; drop_cnt=1 (stats build).
//  Two back-to-back CplDs with cpl_hdr_rdy=0 -> second rx_ack is withheld until the first header is accepted.
//  rst asserted during DATA of an 8-QWORD MWr -> all outputs 0 the next edge; the next TLP routes normally.

Source files
------------

// File: rtl/altpcierd_cdma_rx_pkg.sv
// Shared types and constants for the CDMA RX descriptor router.
package altpcierd_cdma_rx_pkg;

  localparam int unsigned DESC_W = 136;
  localparam int unsigned HDR_W  = 128;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [4:0] TYPE_CPL = 5'b01010;
  localparam logic [4:0] TYPE_MEM = 5'b00000;

  typedef enum logic [1:0] {RT_CPL, RT_REQ, RT_DROP} route_e;
  typedef enum logic [1:0] {IDLE, ACK, DATA} state_e;

  // One payload beat as held in the skid FIFO (73 bits)
  typedef struct packed {
    logic              last;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } beat_t;

  function automatic route_e classify(input logic [4:0] tlp_type);
    route_e rt;
    case (tlp_type)
      TYPE_CPL: rt = RT_CPL;
      TYPE_MEM: rt = RT_REQ;
      default:  rt = RT_DROP;
    endcase
    return rt;
  endfunction

endpackage

// File: rtl/altpcierd_cdma_rx_skid_fifo.sv
// Payload skid FIFO: power-of-2 depth, wrapping pointers, occupancy count output.
module altpcierd_cdma_rx_skid_fifo
  import altpcierd_cdma_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr,
  input  beat_t                   i_wdata,
  input  logic                    i_rd,
  output beat_t                   o_rdata,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  beat_t         r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_rd    = i_rd && !o_empty;
  // A write at full is accepted only when a read frees the slot in the same cycle
  assign w_wr    = i_wr && (!w_full || w_rd);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_wr && w_full && !w_rd));

endmodule

// File: rtl/altpcierd_cdma_rx_router.sv
// Acks RX descriptors, routes headers to cpl/req queues and payload to a skid FIFO.
// Define RX_ROUTE_STATS_EN to add saturating cpl/req/drop counters.
module altpcierd_cdma_rx_router
  import altpcierd_cdma_rx_pkg::*;
#(
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned WS_THRESH  = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              rx_req,
  input  logic [DESC_W-1:0] rx_desc,
  output logic              rx_ack,
  input  logic              rx_dfr,
  input  logic              rx_dv,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [BE_W-1:0]   rx_be,
  output logic              rx_ws,
  output logic              cpl_hdr_vld,
  input  logic              cpl_hdr_rdy,
  output logic              req_hdr_vld,
  input  logic              req_hdr_rdy,
  output logic [HDR_W-1:0]  hdr_out,
  output logic              dat_vld,
  input  logic              dat_rdy,
  output logic [DATA_W-1:0] dat_data,
  output logic [BE_W-1:0]   dat_be,
  output logic              dat_last
`ifdef RX_ROUTE_STATS_EN
  ,
  output logic [CNT_W-1:0]  cpl_cnt,
  output logic [CNT_W-1:0]  req_cnt,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(SKID_DEPTH) + 1;

  state_e           r_state;
  route_e           r_route;
  logic             r_has_pl;
  logic             r_ack;
  logic             r_ws;
  logic             r_cpl_vld;
  logic             r_req_vld;
  logic [HDR_W-1:0] r_hdr;

  route_e           w_in_route;
  logic             w_blocked;
  logic             w_wr;
  logic             w_rd;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_occ_next;
  beat_t            w_wbeat;
  beat_t            w_rbeat;
  logic             w_unused;

  assign w_unused   = ^rx_desc[DESC_W-1:HDR_W];
  assign w_in_route = classify(rx_desc[124:120]);
  // Only the class whose header slot is still occupied has to wait
  assign w_blocked  = (w_in_route == RT_CPL && r_cpl_vld) ||
                      (w_in_route == RT_REQ && r_req_vld);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_route   <= RT_DROP;
      r_has_pl  <= 1'b0;
      r_ack     <= 1'b0;
      r_cpl_vld <= 1'b0;
      r_req_vld <= 1'b0;
      r_hdr     <= '0;
    end else begin
      r_ack <= 1'b0;
      if (r_cpl_vld && cpl_hdr_rdy) r_cpl_vld <= 1'b0;
      if (r_req_vld && req_hdr_rdy) r_req_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_req && !w_blocked) begin
            r_state  <= ACK;
            r_ack    <= 1'b1;
            r_hdr    <= rx_desc[HDR_W-1:0];
            r_route  <= w_in_route;
            r_has_pl <= rx_desc[126];
            if (w_in_route == RT_CPL) r_cpl_vld <= 1'b1;
            if (w_in_route == RT_REQ) r_req_vld <= 1'b1;
          end
        end
        ACK:     r_state <= r_has_pl ? DATA : IDLE;
        DATA:    if (rx_dv && !rx_dfr) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_wr    = (r_state == DATA) && rx_dv && (r_route != RT_DROP);
  assign w_wbeat = '{last: !rx_dfr, be: rx_be, data: rx_data};
  assign w_rd    = dat_vld && dat_rdy;

  altpcierd_cdma_rx_skid_fifo #(
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk_in),
    .rst     (rst),
    .i_wr    (w_wr),
    .i_wdata (w_wbeat),
    .i_rd    (w_rd),
    .o_rdata (w_rbeat),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Throttle on the occupancy that will exist after this edge
  assign w_occ_next = {1'b0, w_count} + (CW+1)'(w_wr) - (CW+1)'(w_rd);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_ws <= 1'b0;
    else     r_ws <= (w_occ_next >= (CW+1)'(WS_THRESH));
  end

  assign rx_ack      = r_ack;
  assign rx_ws       = r_ws;
  assign cpl_hdr_vld = r_cpl_vld;
  assign req_hdr_vld = r_req_vld;
  assign hdr_out     = r_hdr;
  assign dat_vld     = !w_empty;
  assign dat_data    = w_rbeat.data;
  assign dat_be      = w_rbeat.be;
  assign dat_last    = w_rbeat.last;

`ifdef RX_ROUTE_STATS_EN
  logic [CNT_W-1:0] r_cpl_cnt;
  logic [CNT_W-1:0] r_req_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  // Saturating per-class counters, bumped once per acked descriptor
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cpl_cnt  <= '0;
      r_req_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (r_state == ACK) begin
      case (r_route)
        RT_CPL:  if (r_cpl_cnt  != '1) r_cpl_cnt  <= r_cpl_cnt  + CNT_W'(1);
        RT_REQ:  if (r_req_cnt  != '1) r_req_cnt  <= r_req_cnt  + CNT_W'(1);
        default: if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      endcase
    end
  end

  assign cpl_cnt  = r_cpl_cnt;
  assign req_cnt  = r_req_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
